// File: rtl/flow_sched_pkg.sv
// Shared definitions for the flow input scheduler.
//  - flow count and field widths
//  - per-flow FSM state encoding
//  - tagged words sent to the accelerator ({tag, payload})
//  - helpers: block area (ext_size^2) and one-hot to tag encoding
package flow_sched_pkg;

  localparam int FLUX    = 4;
  localparam int DATA_W  = 8;
  localparam int SIZE_W  = 7;
  localparam int ALPHA_W = 3;
  localparam int TAG_W   = $clog2(FLUX);
  // ext_size^2 needs twice the ext_size width (127^2 = 16129).
  localparam int CNT_W   = 2 * SIZE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CFG    = 2'd1,
    STREAM = 2'd2
  } flow_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } pel_word_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SIZE_W-1:0] ext_size;
  } size_word_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [ALPHA_W-1:0] alpha;
  } alpha_word_t;

  function automatic logic [CNT_W-1:0] block_area(input logic [SIZE_W-1:0] s);
    return CNT_W'(s) * CNT_W'(s);
  endfunction

  function automatic logic [TAG_W-1:0] onehot_to_tag(input logic [FLUX-1:0] oh);
    logic [TAG_W-1:0] t;
    t = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (oh[i]) t = t | TAG_W'(i);
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//  clk, rst (sync, active-low)
//  req     in  N  request vector
//  advance in  1  allow the pointer to move past the current grant
//  gnt     out N  one-hot grant (combinational), zero when no request
// The search starts at the pointer; after a grant the pointer moves to
// grant+1 mod N, and it holds when nothing is granted.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/flow_input_scheduler.sv
// Shares the tagged accelerator input stream between FLUX requesters.
// Each flow accepts one job config, issues it on the three config ports,
// then streams exactly ext_size^2 pixels. Pixels of all flows interleave
// round-robin, skipping flows whose accelerator FIFO is full.
//  clk, rst (sync, active-low)
//  cfg_valid/cfg_ext_size/cfg_v_alpha/cfg_h_alpha in : per-flow job request
//  cfg_ready      out : flow idle, config accepted on valid&ready
//  pix_valid/pix_data in, pix_ready out : per-flow pixel handshake
//  ext_size_din/v_alpha_din/h_alpha_din/cfg_write out : tagged config write
//  cfg_full       in  : per-flow config FIFO full
//  in_pel_din/in_pel_write out, in_pel_full in : tagged pixel write
//  flow_busy      out : flow in CFG or STREAM
//  flow_done      out : pulse with the last pixel (or config when ext_size=0)
module flow_input_scheduler
  import flow_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FLUX-1:0]           cfg_valid,
  input  logic [FLUX*SIZE_W-1:0]    cfg_ext_size,
  input  logic [FLUX*ALPHA_W-1:0]   cfg_v_alpha,
  input  logic [FLUX*ALPHA_W-1:0]   cfg_h_alpha,
  output logic [FLUX-1:0]           cfg_ready,
  input  logic [FLUX-1:0]           pix_valid,
  input  logic [FLUX*DATA_W-1:0]    pix_data,
  output logic [FLUX-1:0]           pix_ready,
  output logic [TAG_W+SIZE_W-1:0]   ext_size_din,
  output logic [TAG_W+ALPHA_W-1:0]  v_alpha_din,
  output logic [TAG_W+ALPHA_W-1:0]  h_alpha_din,
  output logic                      cfg_write,
  input  logic [FLUX-1:0]           cfg_full,
  output logic [TAG_W+DATA_W-1:0]   in_pel_din,
  output logic                      in_pel_write,
  input  logic [FLUX-1:0]           in_pel_full,
  output logic [FLUX-1:0]           flow_busy,
  output logic [FLUX-1:0]           flow_done
);

  logic [FLUX-1:0] cfg_req, pix_req, cfg_gnt, pix_gnt;
  logic [FLUX-1:0] pix_last, size_zero, idle_d, done_d;
  logic [FLUX-1:0][SIZE_W-1:0]  size_all;
  logic [FLUX-1:0][ALPHA_W-1:0] v_all, h_all;

  size_word_t      ext_size_q;
  alpha_word_t     v_alpha_q, h_alpha_q;
  pel_word_t       in_pel_q;
  logic            cfg_write_q, in_pel_write_q;
  logic [FLUX-1:0] cfg_ready_q, flow_busy_q, flow_done_q;

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_flow
      flow_state_t        state_q, state_d;
      logic [SIZE_W-1:0]  size_q;
      logic [ALPHA_W-1:0] v_q, h_q;
      logic [CNT_W-1:0]   target_q, count_q;
      logic               accept;

      // cfg_ready_q mirrors IDLE outside reset, so this only fires when idle.
      assign accept = cfg_valid[gi] & cfg_ready_q[gi];

      always_comb begin
        state_d = state_q;
        case (state_q)
          IDLE:    if (accept) state_d = CFG;
          CFG:     if (cfg_gnt[gi]) state_d = (size_q == '0) ? IDLE : STREAM;
          STREAM:  if (pix_gnt[gi] && pix_last[gi]) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          state_q  <= IDLE;
          size_q   <= '0;
          v_q      <= '0;
          h_q      <= '0;
          target_q <= '0;
          count_q  <= '0;
        end else begin
          state_q <= state_d;
          if (accept) begin
            size_q   <= cfg_ext_size[gi*SIZE_W +: SIZE_W];
            v_q      <= cfg_v_alpha[gi*ALPHA_W +: ALPHA_W];
            h_q      <= cfg_h_alpha[gi*ALPHA_W +: ALPHA_W];
            target_q <= block_area(cfg_ext_size[gi*SIZE_W +: SIZE_W]);
            count_q  <= '0;
          end else if (pix_gnt[gi]) begin
            count_q <= count_q + 1'b1;
          end
        end
      end

      // Requests are masked during reset so no handshake completes then.
      assign cfg_req[gi]   = rst & (state_q == CFG) & ~cfg_full[gi];
      assign pix_req[gi]   = rst & (state_q == STREAM) & pix_valid[gi] & ~in_pel_full[gi];
      // count_q holds pixels already granted; this grant is the last one.
      assign pix_last[gi]  = ((count_q + 1'b1) == target_q);
      assign size_zero[gi] = (size_q == '0);
      assign idle_d[gi]    = (state_d == IDLE);
      assign size_all[gi]  = size_q;
      assign v_all[gi]     = v_q;
      assign h_all[gi]     = h_q;
    end
  endgenerate

  rr_arbiter #(.N(FLUX)) u_cfg_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cfg_req),
    .advance (1'b1),
    .gnt     (cfg_gnt)
  );

  rr_arbiter #(.N(FLUX)) u_pix_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (pix_req),
    .advance (1'b1),
    .gnt     (pix_gnt)
  );

  logic [TAG_W-1:0]   cfg_tag, pix_tag;
  logic [SIZE_W-1:0]  size_sel;
  logic [ALPHA_W-1:0] v_sel, h_sel;
  logic [DATA_W-1:0]  data_sel;

  always_comb begin
    cfg_tag  = onehot_to_tag(cfg_gnt);
    pix_tag  = onehot_to_tag(pix_gnt);
    size_sel = '0;
    v_sel    = '0;
    h_sel    = '0;
    data_sel = '0;
    for (int f = 0; f < FLUX; f++) begin
      if (cfg_gnt[f]) begin
        size_sel = size_all[f];
        v_sel    = v_all[f];
        h_sel    = h_all[f];
      end
      if (pix_gnt[f]) data_sel = pix_data[f*DATA_W +: DATA_W];
    end
    // A zero-size job finishes with its config write.
    done_d = (pix_gnt & pix_last) | (cfg_gnt & size_zero);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_ready_q    <= '0;
      flow_busy_q    <= '0;
      flow_done_q    <= '0;
      cfg_write_q    <= 1'b0;
      ext_size_q     <= '0;
      v_alpha_q      <= '0;
      h_alpha_q      <= '0;
      in_pel_write_q <= 1'b0;
      in_pel_q       <= '0;
    end else begin
      cfg_ready_q    <= idle_d;
      flow_busy_q    <= ~idle_d;
      flow_done_q    <= done_d;
      cfg_write_q    <= |cfg_gnt;
      in_pel_write_q <= |pix_gnt;
      if (|cfg_gnt) begin
        ext_size_q <= {cfg_tag, size_sel};
        v_alpha_q  <= {cfg_tag, v_sel};
        h_alpha_q  <= {cfg_tag, h_sel};
      end else begin
        ext_size_q <= '0;
        v_alpha_q  <= '0;
        h_alpha_q  <= '0;
      end
      in_pel_q <= (|pix_gnt) ? {pix_tag, data_sel} : '0;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign pix_ready    = pix_gnt;
  assign ext_size_din = ext_size_q;
  assign v_alpha_din  = v_alpha_q;
  assign h_alpha_din  = h_alpha_q;
  assign cfg_write    = cfg_write_q;
  assign in_pel_din   = in_pel_q;
  assign in_pel_write = in_pel_write_q;
  assign flow_busy    = flow_busy_q;
  assign flow_done    = flow_done_q;

endmodule

// File: tb/tb_flow_input_scheduler.sv
module tb_flow_input_scheduler;
  import flow_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [FLUX-1:0]          cfg_valid, cfg_ready, pix_valid, pix_ready;
  logic [FLUX-1:0]          cfg_full, in_pel_full, flow_busy, flow_done;
  logic [FLUX*SIZE_W-1:0]   cfg_ext_size;
  logic [FLUX*ALPHA_W-1:0]  cfg_v_alpha, cfg_h_alpha;
  logic [FLUX*DATA_W-1:0]   pix_data;
  logic [TAG_W+SIZE_W-1:0]  ext_size_din;
  logic [TAG_W+ALPHA_W-1:0] v_alpha_din, h_alpha_din;
  logic [TAG_W+DATA_W-1:0]  in_pel_din;
  logic                     cfg_write, in_pel_write;

  flow_input_scheduler dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ext_size(cfg_ext_size),
    .cfg_v_alpha(cfg_v_alpha), .cfg_h_alpha(cfg_h_alpha), .cfg_ready(cfg_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .ext_size_din(ext_size_din), .v_alpha_din(v_alpha_din), .h_alpha_din(h_alpha_din),
    .cfg_write(cfg_write), .cfg_full(cfg_full),
    .in_pel_din(in_pel_din), .in_pel_write(in_pel_write), .in_pel_full(in_pel_full),
    .flow_busy(flow_busy), .flow_done(flow_done)
  );

  typedef struct packed {
    logic [FLUX-1:0]              mask;
    logic [FLUX-1:0][SIZE_W-1:0]  size;
    logic [FLUX-1:0][ALPHA_W-1:0] v;
    logic [FLUX-1:0][ALPHA_W-1:0] h;
    logic [FLUX-1:0][13:0]        exp_pix;
    logic [2:0]                   n_done;
    logic [3:0][1:0]              done_ord;
    logic                         rot;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  int vectors = 0;
  int miscompares = 0;
  int sent [FLUX];
  int rcv [FLUX];
  int job_size [FLUX];
  int job_v [FLUX];
  int job_h [FLUX];
  bit cfg_seen [FLUX];
  int done_q [$];
  int cfgtag_q [$];
  bit rot_chk;
  int last_tag;

  function automatic void chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] pix_byte(input int f, input int k);
    return DATA_W'((f * 61 + k * 7 + 3) % 256);
  endfunction

  function automatic int q_at(input int k, input bit use_done);
    if (use_done) return (k < done_q.size()) ? done_q[k] : -1;
    return (k < cfgtag_q.size()) ? cfgtag_q[k] : -1;
  endfunction

  task automatic drive_pix();
    for (int f = 0; f < FLUX; f++) pix_data[f*DATA_W +: DATA_W] = pix_byte(f, sent[f]);
  endtask

  task automatic clear_tb();
    for (int f = 0; f < FLUX; f++) begin
      sent[f] = 0; rcv[f] = 0; job_size[f] = 0; job_v[f] = 0; job_h[f] = 0;
      cfg_seen[f] = 1'b0;
    end
    done_q.delete();
    cfgtag_q.delete();
    rot_chk = 1'b0;
    last_tag = -1;
    drive_pix();
  endtask

  task automatic monitor();
    int tp, tc;
    bit all_rem, ok;
    tp = int'(in_pel_din[DATA_W +: TAG_W]);
    tc = int'(ext_size_din[SIZE_W +: TAG_W]);
    if (in_pel_write) begin
      all_rem = 1'b1;
      for (int f = 0; f < FLUX; f++)
        if (rcv[f] >= job_size[f] * job_size[f]) all_rem = 1'b0;
      chk($sformatf("pel_before_cfg_f%0d", tp), int'(cfg_seen[tp]), 1);
      chk($sformatf("pel_data_f%0d_k%0d", tp, rcv[tp]), int'(in_pel_din[DATA_W-1:0]),
          int'(pix_byte(tp, rcv[tp])));
      rcv[tp]++;
      chk($sformatf("pel_overrun_f%0d", tp), int'(rcv[tp] <= job_size[tp] * job_size[tp]), 1);
      if (rot_chk && last_tag >= 0 && all_rem) chk("rr_order", tp, (last_tag + 1) % FLUX);
      last_tag = tp;
    end else begin
      chk("pel_idle_din", int'(in_pel_din), 0);
    end
    if (cfg_write) begin
      chk("cfg_v_tag", int'(v_alpha_din[ALPHA_W +: TAG_W]), tc);
      chk("cfg_h_tag", int'(h_alpha_din[ALPHA_W +: TAG_W]), tc);
      chk($sformatf("cfg_size_f%0d", tc), int'(ext_size_din[SIZE_W-1:0]), job_size[tc]);
      chk($sformatf("cfg_v_f%0d", tc), int'(v_alpha_din[ALPHA_W-1:0]), job_v[tc]);
      chk($sformatf("cfg_h_f%0d", tc), int'(h_alpha_din[ALPHA_W-1:0]), job_h[tc]);
      chk($sformatf("cfg_dup_f%0d", tc), int'(cfg_seen[tc]), 0);
      cfg_seen[tc] = 1'b1;
      cfgtag_q.push_back(tc);
    end else begin
      chk("cfg_idle_din", int'({ext_size_din, v_alpha_din, h_alpha_din}), 0);
    end
    for (int f = 0; f < FLUX; f++) begin
      if (flow_done[f]) begin
        done_q.push_back(f);
        ok = (in_pel_write && tp == f && rcv[f] == job_size[f] * job_size[f]) ||
             (cfg_write && tc == f && job_size[f] == 0);
        chk($sformatf("done_cause_f%0d", f), int'(ok), 1);
      end
    end
  endtask

  // One clock: sample handshakes before the edge, outputs 1 time unit after.
  task automatic step();
    logic [FLUX-1:0] rdy, acc;
    @(negedge clk);
    rdy = pix_ready;
    acc = cfg_valid & cfg_ready;
    @(posedge clk);
    #1;
    for (int f = 0; f < FLUX; f++) begin
      if (rdy[f]) sent[f]++;
      if (acc[f]) cfg_valid[f] = 1'b0;
    end
    drive_pix();
    monitor();
  endtask

  task automatic req(input int f, input int size, input int v, input int h);
    job_size[f] = size; job_v[f] = v; job_h[f] = h;
    cfg_ext_size[f*SIZE_W +: SIZE_W]  = SIZE_W'(size);
    cfg_v_alpha[f*ALPHA_W +: ALPHA_W] = ALPHA_W'(v);
    cfg_h_alpha[f*ALPHA_W +: ALPHA_W] = ALPHA_W'(h);
    cfg_valid[f] = 1'b1;
  endtask

  task automatic wait_done(input int n, input string name);
    int cyc;
    cyc = 0;
    while ((done_q.size() < n || cfg_valid != '0) && cyc < 20000) begin
      step();
      cyc++;
    end
    chk({name, "_timeout"}, int'(cyc < 20000), 1);
    repeat (4) step();
  endtask

  task automatic wait_rcv(input int f, input int n, input string name);
    int cyc;
    cyc = 0;
    while (rcv[f] < n && cyc < 20000) begin
      step();
      cyc++;
    end
    chk({name, "_timeout"}, int'(cyc < 20000), 1);
  endtask

  task automatic chk_quiet(input string name, input int exp_ready);
    chk({name, "_cfg_ready"}, int'(cfg_ready), exp_ready);
    chk({name, "_busy"}, int'(flow_busy), 0);
    chk({name, "_done"}, int'(flow_done), 0);
    chk({name, "_pix_ready"}, int'(pix_ready), 0);
    chk({name, "_writes"}, int'({cfg_write, in_pel_write}), 0);
    chk({name, "_dins"}, int'({ext_size_din, v_alpha_din, h_alpha_din, in_pel_din}), 0);
  endtask

  initial begin
    // {mask, size, v, h, exp_pix, n_done, done_ord, rot}; element [3] listed first
    vecs[0] = '{4'b1000, {7'd15, 7'd0, 7'd0, 7'd0}, {3'd2, 3'd0, 3'd0, 3'd0},
                {3'd0, 3'd0, 3'd0, 3'd0}, {14'd225, 14'd0, 14'd0, 14'd0},
                3'd1, {2'd0, 2'd0, 2'd0, 2'd3}, 1'b0};
    vecs[1] = '{4'b1111, {7'd15, 7'd23, 7'd39, 7'd71}, {3'd4, 3'd3, 3'd2, 3'd1},
                {3'd7, 3'd5, 3'd6, 3'd0}, {14'd225, 14'd529, 14'd1521, 14'd5041},
                3'd4, {2'd0, 2'd1, 2'd2, 2'd3}, 1'b1};
    vecs[2] = '{4'b0010, {7'd0, 7'd0, 7'd0, 7'd0}, {3'd0, 3'd0, 3'd5, 3'd0},
                {3'd0, 3'd0, 3'd3, 3'd0}, {14'd0, 14'd0, 14'd0, 14'd0},
                3'd1, {2'd0, 2'd0, 2'd0, 2'd1}, 1'b0};
    vecs[3] = '{4'b0101, {7'd0, 7'd3, 7'd0, 7'd5}, {3'd0, 3'd6, 3'd0, 3'd1},
                {3'd0, 3'd2, 3'd0, 3'd7}, {14'd0, 14'd9, 14'd0, 14'd25},
                3'd2, {2'd0, 2'd0, 2'd0, 2'd2}, 1'b0};
    vecs[4] = '{4'b0110, {7'd0, 7'd0, 7'd2, 7'd0}, {3'd0, 3'd1, 3'd3, 3'd0},
                {3'd0, 3'd4, 3'd2, 3'd0}, {14'd0, 14'd0, 14'd4, 14'd0},
                3'd2, {2'd0, 2'd0, 2'd1, 2'd2}, 1'b0};
    vecs[5] = '{4'b0001, {7'd0, 7'd0, 7'd0, 7'd1}, {3'd0, 3'd0, 3'd0, 3'd3},
                {3'd0, 3'd0, 3'd0, 3'd5}, {14'd0, 14'd0, 14'd0, 14'd1},
                3'd1, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b0};
    vecs[6] = '{4'b0100, {7'd0, 7'd127, 7'd0, 7'd0}, {3'd0, 3'd7, 3'd0, 3'd0},
                {3'd0, 3'd7, 3'd0, 3'd0}, {14'd0, 14'd16129, 14'd0, 14'd0},
                3'd1, {2'd0, 2'd0, 2'd0, 2'd2}, 1'b0};

    rst = 1'b0;
    cfg_valid = '0; cfg_ext_size = '0; cfg_v_alpha = '0; cfg_h_alpha = '0;
    pix_valid = '1; cfg_full = '0; in_pel_full = '0;
    clear_tb();

    // Reset held for three cycles, then released.
    repeat (3) begin
      step();
      chk_quiet("reset", 0);
    end
    rst = 1'b1;
    step();
    chk_quiet("after_reset", 15);

    // Table-driven jobs.
    for (int i = 0; i < NVEC; i++) begin
      clear_tb();
      rot_chk = vecs[i].rot;
      for (int f = 0; f < FLUX; f++)
        if (vecs[i].mask[f])
          req(f, int'(vecs[i].size[f]), int'(vecs[i].v[f]), int'(vecs[i].h[f]));
      wait_done(int'(vecs[i].n_done), $sformatf("v%0d", i));
      for (int f = 0; f < FLUX; f++) begin
        chk($sformatf("v%0d_pix_f%0d", i, f), rcv[f], int'(vecs[i].exp_pix[f]));
        chk($sformatf("v%0d_ready_vs_write_f%0d", i, f), sent[f], rcv[f]);
      end
      chk($sformatf("v%0d_cfg_count", i), cfgtag_q.size(), $countones(vecs[i].mask));
      chk($sformatf("v%0d_done_count", i), done_q.size(), int'(vecs[i].n_done));
      for (int k = 0; k < int'(vecs[i].n_done); k++)
        chk($sformatf("v%0d_done_ord%0d", i, k), q_at(k, 1'b1), int'(vecs[i].done_ord[k]));
      chk($sformatf("v%0d_end", i), int'({cfg_ready, flow_busy}), 32'hF0);
    end

    // Backpressure on flow 1 for 20 cycles.
    begin
      int r1, others;
      clear_tb();
      req(0, 15, 1, 1); req(1, 15, 2, 2); req(2, 15, 3, 3);
      wait_rcv(1, 20, "bp_start");
      in_pel_full[1] = 1'b1;
      r1 = rcv[1];
      others = rcv[0] + rcv[2];
      repeat (20) step();
      chk("bp_no_tag1", rcv[1], r1);
      chk("bp_others_20", rcv[0] + rcv[2] - others, 20);
      chk("bp_no_ready1", sent[1], rcv[1]);
      in_pel_full[1] = 1'b0;
      repeat (3) step();
      chk("bp_resume", int'(rcv[1] > r1), 1);
      wait_done(3, "bp");
      for (int f = 0; f < 3; f++) chk($sformatf("bp_total_f%0d", f), rcv[f], 225);
    end

    // Simultaneous configs for flows 0 and 2 with flow 0's config FIFO full.
    clear_tb();
    cfg_full[0] = 1'b1;
    req(0, 4, 1, 2); req(2, 3, 5, 6);
    repeat (6) step();
    chk("cf_one_cfg", cfgtag_q.size(), 1);
    chk("cf_first_tag", q_at(0, 1'b0), 2);
    chk("cf_no_pix0", rcv[0], 0);
    chk("cf_busy0", int'(flow_busy[0]), 1);
    cfg_full[0] = 1'b0;
    wait_done(2, "cf");
    chk("cf_second_tag", q_at(1, 1'b0), 0);
    chk("cf_total_f0", rcv[0], 16);
    chk("cf_total_f2", rcv[2], 9);

    // Reset in the middle of a job, then fresh jobs.
    clear_tb();
    req(0, 71, 2, 3);
    wait_rcv(0, 100, "mr_start");
    rst = 1'b0;
    step();
    chk_quiet("mr_reset", 0);
    rst = 1'b1;
    clear_tb();
    step();
    chk_quiet("mr_release", 15);
    repeat (3) step();
    chk("mr_no_writes", rcv[0], 0);
    req(0, 9, 4, 5);
    wait_done(1, "mr_job");
    chk("mr_total", rcv[0], 81);
    chk("mr_sent", sent[0], 81);
    clear_tb();
    req(3, 0, 6, 1);
    wait_done(1, "mr_zero");
    chk("mr_zero_cfg", cfgtag_q.size(), 1);
    chk("mr_zero_done", q_at(0, 1'b1), 3);
    chk("mr_zero_pix", rcv[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
